morse_capture_ctrl: RTL

Sequencer that turns two raw push-buttons (dot, dash) into framed Morse code words for downstream decode logic. It synchronises and debounces both buttons, records one symbol per press, and closes a word after 4 symbols or an inter-word silence. The word is offered on a valid/ready port. It sits between the board button pins and the Morse decoder/display path.

---
 rtl/morse_pkg.sv | 18 +
 rtl/morse_debounce.sv | 53 +++++
 rtl/morse_capture_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/morse_pkg.sv
// rtl/morse_pkg.sv - shared state encoding and symbol constants for the Morse capture path
// Contents:
//   morse_state_t  capture FSM states
//   SYM_DOT/DASH   symbol bit values stored in the code word
//   MAX_SYM        symbols per word before it is closed
package morse_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    OUTPUT  = 2'd2
  } morse_state_t;

  localparam logic SYM_DOT  = 1'b0;
  localparam logic SYM_DASH = 1'b1;
  localparam int   MAX_SYM  = 4;

endpackage

// File: rtl/morse_debounce.sv
// rtl/morse_debounce.sv - button synchroniser, debouncer and press-edge pulse
// Ports:
//   CLKin  in   system clock
//   RSTin  in   asynchronous active-high reset
//   btn_n  in   raw active-low button, asynchronous to CLKin
//   press  out  one-cycle pulse on a debounced 1->0 transition
module morse_debounce
  import morse_pkg::*;
#(
  parameter int DEB_CYCLES = 4
) (
  input  logic CLKin,
  input  logic RSTin,
  input  logic btn_n,
  output logic press
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          deb;
  logic          deb_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge CLKin or posedge RSTin) begin
    if (RSTin) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      deb   <= 1'b1;
      deb_d <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
      deb_d <= deb;
      press <= deb_d & ~deb;
      // The count only advances while the synchronised level disagrees with
      // the debounced one; any agreement (a bounce back) restarts it.
      if (sync2 == deb) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        deb <= sync2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/morse_capture_ctrl.sv
// rtl/morse_capture_ctrl.sv - frames debounced dot/dash presses into Morse code words
// Ports:
//   CLKin, RSTin            clock, asynchronous active-high reset
//   btn_dot_n, btn_dash_n   raw active-low buttons
//   code_out[3:0]           symbol word, bit i = symbol i (1 = dash)
//   len_out[2:0]            symbol count of the offered word
//   valid_out / ready_in    word handshake
//   busy                    word in progress
//   err_pulse               simultaneous press, or press dropped while offering
module morse_capture_ctrl
  import morse_pkg::*;
#(
  parameter int DEB_CYCLES = 4,
  parameter int GAP_CYCLES = 16
) (
  input  logic       CLKin,
  input  logic       RSTin,
  input  logic       btn_dot_n,
  input  logic       btn_dash_n,
  output logic [3:0] code_out,
  output logic [2:0] len_out,
  output logic       valid_out,
  input  logic       ready_in,
  output logic       busy,
  output logic       err_pulse
);

  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  logic dot_press;
  logic dash_press;

  morse_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_dot (
    .CLKin (CLKin),
    .RSTin (RSTin),
    .btn_n (btn_dot_n),
    .press (dot_press)
  );

  morse_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_dash (
    .CLKin (CLKin),
    .RSTin (RSTin),
    .btn_n (btn_dash_n),
    .press (dash_press)
  );

  morse_state_t  state, state_n;
  logic [3:0]    code, code_n;
  logic [2:0]    len, len_n;
  logic [GW-1:0] gap, gap_n;
  logic          err_n;
  logic          both;
  logic          any;
  logic          sym;

  always_ff @(posedge CLKin or posedge RSTin) begin
    if (RSTin) begin
      state     <= IDLE;
      code      <= '0;
      len       <= '0;
      gap       <= '0;
      err_pulse <= 1'b0;
      busy      <= 1'b0;
      valid_out <= 1'b0;
    end else begin
      state     <= state_n;
      code      <= code_n;
      len       <= len_n;
      gap       <= gap_n;
      err_pulse <= err_n;
      // Decoded from the next state so the flags line up with the state register.
      busy      <= (state_n != IDLE);
      valid_out <= (state_n == OUTPUT);
    end
  end

  always_comb begin
    state_n = state;
    code_n  = code;
    len_n   = len;
    gap_n   = gap;
    err_n   = 1'b0;
    both    = dot_press & dash_press;
    any     = dot_press | dash_press;
    sym     = dash_press ? SYM_DASH : SYM_DOT;
    case (state)
      IDLE: begin
        if (both) begin
          err_n = 1'b1;
        end else if (any) begin
          code_n    = '0;
          code_n[0] = sym;
          len_n     = 3'd1;
          gap_n     = '0;
          state_n   = COLLECT;
        end
      end
      COLLECT: begin
        if (both) begin
          // Ambiguous press: nothing stored, but it still counts as activity.
          err_n = 1'b1;
          gap_n = '0;
        end else if (any) begin
          code_n[len[1:0]] = sym;
          len_n = len + 3'd1;
          gap_n = '0;
          if (len_n == 3'(MAX_SYM)) begin
            state_n = OUTPUT;
          end
        end else if (gap == GAP_LAST) begin
          gap_n   = '0;
          state_n = OUTPUT;
        end else begin
          gap_n = gap + 1'b1;
        end
      end
      OUTPUT: begin
        // The offered word is frozen; presses here are reported and discarded.
        if (any) begin
          err_n = 1'b1;
        end
        if (ready_in) begin
          code_n  = '0;
          len_n   = '0;
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign code_out = code;
  assign len_out  = len;

endmodule
